// File: rtl/proc_int_ctrl_if.sv
// proc_int_ctrl_if: request/data/control bundle between the interrupt
// controller and its surroundings. master = device/pipeline side, slave = controller.
interface proc_int_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        irq_in;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      hold;
    logic                      rti;
    logic                      rsi;
    logic                      mask_wr;
    logic [NUM_SRC-1:0]        mask_wdata;

    logic                      interrupt;
    logic [ID_W-1:0]           irq_id;
    logic [DATA_W-1:0]         irq_data;
    logic                      busy;
    logic [NUM_SRC-1:0]        pending;
    logic [NUM_SRC-1:0]        ovf;

    modport master (
        output irq_in, src_data, hold, rti, rsi, mask_wr, mask_wdata,
        input  interrupt, irq_id, irq_data, busy, pending, ovf
    );

    modport slave (
        input  irq_in, src_data, hold, rti, rsi, mask_wr, mask_wdata,
        output interrupt, irq_id, irq_data, busy, pending, ovf
    );
endinterface

// File: rtl/proc_int_ctrl.sv
// proc_int_ctrl: NUM_SRC synchronised, maskable, fixed-priority interrupt
// sources feeding a single registered interrupt pulse into fetch. The winning
// source ID and data are held stable for the RDI path until RTI.
// Build option: define INTC_EDGE_EN for edge-triggered pending bits with
// sticky overflow flags; undefined gives level-sensitive pending, ovf = 0.
module proc_int_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    proc_int_ctrl_if.slave io_bus
);
    localparam int ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] w_sync;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_ovf;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_capture;
    logic [DATA_W-1:0]  w_cap_data;

    state_t             r_state;
    logic               r_gap;
    logic               r_int;
    logic               r_busy;
    logic [ID_W-1:0]    r_id;
    logic [DATA_W-1:0]  r_data;

    // Synchroniser chain for the asynchronous request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= io_bus.irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Mask register; all sources enabled out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_mask <= '1;
        else if (io_bus.mask_wr) r_mask <= io_bus.mask_wdata;
    end

    assign w_elig = r_pending & r_mask;
    assign w_any  = |w_elig;

    // Fixed priority: lowest eligible index wins
    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = ID_W'(i);
        end
    end

    assign w_cap_data = io_bus.src_data[int'(w_win)*DATA_W +: DATA_W];

    // Capture only from IDLE after the post-RTI idle cycle has elapsed
    assign w_capture = (r_state == ST_IDLE) && !r_gap && w_any;

`ifdef INTC_EDGE_EN
    logic [NUM_SRC-1:0] r_sync_d;
    logic [NUM_SRC-1:0] r_ovf;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr_pend;
    logic [NUM_SRC-1:0] w_ovf_set;
    logic [NUM_SRC-1:0] w_ovf_clr;

    // Rise detection, pending consumption and overflow set/clear terms
    always_comb begin
        w_rise     = w_sync & ~r_sync_d;
        w_clr_pend = w_capture ? (NUM_SRC'(1) << w_win) : '0;
        w_ovf_set  = w_rise & r_pending;
        w_ovf_clr  = io_bus.mask_wr ? '1 : '0;
        if ((r_state == ST_ACTIVE) && io_bus.rsi) w_ovf_clr |= NUM_SRC'(1) << r_id;
    end

    // Edge-mode pending and sticky overflow; a new set wins over any clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d  <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_sync_d  <= w_sync;
            r_pending <= (r_pending & ~w_clr_pend) | w_rise;
            r_ovf     <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
        end
    end

    assign w_ovf = r_ovf;
`else
    // Level-mode pending simply follows the synchronised request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_sync;
    end

    assign w_ovf = '0;
`endif

    // Service FSM: IDLE -> FIRE (interrupt) -> ACTIVE (handler) -> IDLE on rti
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gap   <= 1'b0;
            r_int   <= 1'b0;
            r_busy  <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (w_capture) begin
                        r_id    <= w_win;
                        r_data  <= w_cap_data;
                        r_int   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    if (!io_bus.hold) begin
                        r_int   <= 1'b0;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (io_bus.rti) begin
                        r_busy  <= 1'b0;
                        r_gap   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_int   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.interrupt = r_int;
    assign io_bus.busy      = r_busy;
    assign io_bus.irq_id    = r_id;
    assign io_bus.irq_data  = r_data;
    assign io_bus.pending   = r_pending;
    assign io_bus.ovf       = w_ovf;

endmodule

// File: tb/tb_proc_int_ctrl.sv
// tb_proc_int_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the interrupt controller.
module tb_proc_int_ctrl;
    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int SS   = 2;
    localparam int ID_W = $clog2(NS);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    proc_int_ctrl_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

    proc_int_ctrl #(.NUM_SRC(NS), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [NS-1:0]   hist [$];
    logic [NS-1:0]   m_pend, m_ovf, m_mask;
    int              m_phase;   // 0 no service, 1 requesting, 2 handler running
    bit              m_gap;
    logic [ID_W-1:0] m_id;
    logic [DW-1:0]   m_data;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i <= SS; i++) hist.push_front('0);
        m_pend  = '0;
        m_ovf   = '0;
        m_mask  = '1;
        m_phase = 0;
        m_gap   = 1'b0;
        m_id    = '0;
        m_data  = '0;
    endtask

    task automatic model_step();
        logic [NS-1:0] sync_now, sync_old, elig;
`ifdef INTC_EDGE_EN
        logic [NS-1:0] rise, taken, oset, oclr;
`endif
        int win;
        bit cap;
        sync_now = hist[SS-1];
        sync_old = hist[SS];
        elig = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;
        cap = (m_phase == 0) && !m_gap && (win >= 0);
`ifdef INTC_EDGE_EN
        rise  = sync_now & ~sync_old;
        taken = '0;
        if (cap) taken[win] = 1'b1;
        oset = rise & m_pend;
        oclr = bus.mask_wr ? '1 : '0;
        if (m_phase == 2 && bus.rsi) oclr[m_id] = 1'b1;
        m_ovf  = (m_ovf & ~oclr) | oset;
        m_pend = (m_pend & ~taken) | rise;
`else
        m_pend = sync_now;
`endif
        case (m_phase)
            0: begin
                if (m_gap) m_gap = 1'b0;
                else if (cap) begin
                    m_id    = ID_W'(win);
                    m_data  = bus.src_data[win*DW +: DW];
                    m_phase = 1;
                end
            end
            1: if (!bus.hold) m_phase = 2;
            default: if (bus.rti) begin
                m_phase = 0;
                m_gap   = 1'b1;
            end
        endcase
        if (bus.mask_wr) m_mask = bus.mask_wdata;
        hist.push_front(bus.irq_in);
        void'(hist.pop_back());
    endtask

    task automatic compare();
        chk("interrupt", 64'(bus.interrupt), 64'(m_phase == 1));
        chk("busy",      64'(bus.busy),      64'(m_phase != 0));
        chk("irq_id",    64'(bus.irq_id),    64'(m_id));
        chk("irq_data",  64'(bus.irq_data),  64'(m_data));
        chk("pending",   64'(bus.pending),   64'(m_pend));
        chk("ovf",       64'(bus.ovf),       64'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet_inputs();
        bus.irq_in     = '0;
        bus.hold       = 1'b0;
        bus.rti        = 1'b0;
        bus.rsi        = 1'b0;
        bus.mask_wr    = 1'b0;
        bus.mask_wdata = '1;
    endtask

    task automatic pulse_rti();
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = 32'hA5A5_0000 | i;
        model_reset();
        #1;
        chk("reset_int", 64'(bus.interrupt), 64'd0);
        chk("reset_pend", 64'(bus.pending), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single one-cycle pulse on source 2: interrupt after edge 4
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = '0;
        idle(2);
        chk("t1_no_early_int", 64'(bus.interrupt), 64'd0);
        tick();
        chk("t1_int", 64'(bus.interrupt), 64'd1);
        chk("t1_id", 64'(bus.irq_id), 64'd2);
        chk("t1_data", 64'(bus.irq_data), 64'h A5A5_0002);
        tick();
        chk("t1_int_one_cycle", 64'(bus.interrupt), 64'd0);
        idle(3);
        chk("t1_busy_held", 64'(bus.busy), 64'd1);
        pulse_rti();
        chk("t1_busy_clr", 64'(bus.busy), 64'd0);
        idle(4);

        // hold high through three FIRE cycles stretches interrupt to four
        cnt = 0;
        bus.hold   = 1'b1;
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = '0;
        if (bus.interrupt) cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.interrupt) cnt++;
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.interrupt) cnt++;
        end
        chk("t4_int_len", 64'(cnt), 64'd4);
        chk("t4_busy", 64'(bus.busy), 64'd1);
        pulse_rti();
        idle(4);

`ifdef INTC_EDGE_EN
        // Simultaneous rises on 1 and 3: served in index order with a gap
        bus.irq_in = 4'b1010;
        tick();
        bus.irq_in = '0;
        idle(3);
        chk("t2_first_id", 64'(bus.irq_id), 64'd1);
        chk("t2_first_int", 64'(bus.interrupt), 64'd1);
        tick();
        pulse_rti();
        tick();
        chk("t2_gap", 64'(bus.interrupt), 64'd0);
        tick();
        chk("t2_second_int", 64'(bus.interrupt), 64'd1);
        chk("t2_second_id", 64'(bus.irq_id), 64'd3);
        tick();
        pulse_rti();
        tick();
        chk("t2_pend_empty", 64'(bus.pending), 64'd0);
        idle(3);

        // Two rises on masked source 0 -> overflow, no interrupt; unmask fires it
        bus.mask_wr = 1'b1;
        bus.mask_wdata = 4'b1110;
        tick();
        bus.mask_wr = 1'b0;
        bus.irq_in = 4'b0001;
        tick();
        bus.irq_in = '0;
        idle(2);
        bus.irq_in = 4'b0001;
        tick();
        bus.irq_in = '0;
        idle(6);
        chk("t3_ovf", 64'(bus.ovf), 64'd1);
        chk("t3_no_int", 64'(bus.busy), 64'd0);
        bus.mask_wr = 1'b1;
        bus.mask_wdata = 4'b1111;
        tick();
        bus.mask_wr = 1'b0;
        chk("t3_ovf_clr", 64'(bus.ovf), 64'd0);
        tick();
        chk("t3_int", 64'(bus.interrupt), 64'd1);
        chk("t3_id", 64'(bus.irq_id), 64'd0);
        tick();
        pulse_rti();
        idle(3);
`else
        // Source 1 held high across rti re-fires two cycles later
        bus.irq_in = 4'b0010;
        idle(4);
        chk("lv_int", 64'(bus.interrupt), 64'd1);
        chk("lv_id", 64'(bus.irq_id), 64'd1);
        tick();
        pulse_rti();
        tick();
        chk("lv_gap", 64'(bus.interrupt), 64'd0);
        tick();
        chk("lv_refire", 64'(bus.interrupt), 64'd1);
        chk("lv_refire_id", 64'(bus.irq_id), 64'd1);
        bus.irq_in = '0;
        tick();
        pulse_rti();
        idle(5);
        chk("lv_no_refire", 64'(bus.busy), 64'd0);
`endif

        // Reset during a handler for source 3 clears everything at once
        bus.irq_in = 4'b1000;
        tick();
        bus.irq_in = '0;
        idle(5);
        chk("t5_active_id", 64'(bus.irq_id), 64'd3);
        chk("t5_active_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_int", 64'(bus.interrupt), 64'd0);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        chk("t5_rst_id", 64'(bus.irq_id), 64'd0);
        chk("t5_rst_data", 64'(bus.irq_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        // Mask is back to all-ones: source 3 is served without a mask write
        bus.irq_in = 4'b1000;
        tick();
        bus.irq_in = '0;
        idle(3);
        chk("t5_mask_int", 64'(bus.interrupt), 64'd1);
        chk("t5_mask_id", 64'(bus.irq_id), 64'd3);
        tick();
        pulse_rti();
        idle(3);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NS; b++) if ($urandom_range(0, 7) == 0) bus.irq_in[b] = ~bus.irq_in[b];
            for (int b = 0; b < NS; b++) bus.src_data[b*DW +: DW] = $urandom;
            bus.hold       = ($urandom_range(0, 3) == 0);
            bus.rti        = ($urandom_range(0, 3) == 0);
            bus.rsi        = ($urandom_range(0, 5) == 0);
            bus.mask_wr    = ($urandom_range(0, 39) == 0);
            bus.mask_wdata = NS'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
